// File: rtl/truco_pkg.sv
// Shared FSM state type and truco ladder constants for the scoreboard control unit.
package truco_pkg;

    typedef enum logic [3:0] {
        CLEAR_ALL,
        IDLE,
        WAIT_RODADA,
        INC_A,
        INC_B,
        CHECK_T,
        ADD_A,
        ADD_B,
        NOVA_MAO,
        FIM
    } state_t;

    localparam logic [3:0] VALOR_UM   = 4'd1;
    localparam logic [3:0] VALOR_TRES = 4'd3;
    localparam logic [3:0] VALOR_SEIS = 4'd6;
    localparam logic [3:0] VALOR_NOVE = 4'd9;
    localparam logic [3:0] VALOR_DOZE = 4'd12;

    // Any value off the ladder (or the top rung) lands on the top rung.
    function automatic logic [3:0] proximo_valor(input logic [3:0] valor);
        logic [3:0] prox;
        case (valor)
            VALOR_UM:   prox = VALOR_TRES;
            VALOR_TRES: prox = VALOR_SEIS;
            VALOR_SEIS: prox = VALOR_NOVE;
            VALOR_NOVE: prox = VALOR_DOZE;
            default:    prox = VALOR_DOZE;
        endcase
        return prox;
    endfunction

endpackage

// File: rtl/truco_controle_if.sv
// Bundle between the truco control unit and its surroundings (player pulses,
// datapath strobes/flags, status). master = control unit, slave = environment.
interface truco_controle_if #(
    parameter int W_VALOR = 4
);
    logic               start;
    logic               rodada_a;
    logic               rodada_b;
    logic               truco;
    logic               a_igual12;
    logic               b_igual12;
    logic               ta_igual3;
    logic               tb_igual3;
    logic               load_pa;
    logic               load_pb;
    logic               load_ta;
    logic               load_tb;
    logic               clear_pa;
    logic               clear_pb;
    logic               clear_ta;
    logic               clear_tb;
    logic [W_VALOR-1:0] valor_mao;
    logic               ocupado;
    logic               fim_jogo;
    logic               vencedor_a;
    logic               vencedor_b;

    modport master (
        input  start, rodada_a, rodada_b, truco,
        input  a_igual12, b_igual12, ta_igual3, tb_igual3,
        output load_pa, load_pb, load_ta, load_tb,
        output clear_pa, clear_pb, clear_ta, clear_tb,
        output valor_mao, ocupado, fim_jogo, vencedor_a, vencedor_b
    );

    modport slave (
        output start, rodada_a, rodada_b, truco,
        output a_igual12, b_igual12, ta_igual3, tb_igual3,
        input  load_pa, load_pb, load_ta, load_tb,
        input  clear_pa, clear_pb, clear_ta, clear_tb,
        input  valor_mao, ocupado, fim_jogo, vencedor_a, vencedor_b
    );

endinterface

// File: rtl/truco_controle.sv
// Control unit for the truco scoreboard: turns round/truco pulses into load/clear
// strobes for the points/tentos datapath and tracks hand value and game winner.
module truco_controle
    import truco_pkg::*;
#(
    parameter int                 W_VALOR       = 4,
    parameter logic [W_VALOR-1:0] VALOR_INICIAL = W_VALOR'(VALOR_UM),
    parameter logic [W_VALOR-1:0] VALOR_MAX     = W_VALOR'(VALOR_DOZE)
) (
    input logic              clk,
    input logic              reset,
    truco_controle_if.master bus
);

    state_t             r_state,   w_state_nxt;
    logic [W_VALOR-1:0] r_valor,   w_valor_nxt;
    logic [W_VALOR-1:0] r_rem,     w_rem_nxt;
    logic               r_novo_jogo, w_novo_jogo_nxt;
    logic               r_venc_a,  w_venc_a_nxt;
    logic               r_venc_b,  w_venc_b_nxt;
    logic               w_load_pa, w_load_pb, w_load_ta, w_load_tb;
    logic               w_clear_t;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CLEAR_ALL;
            r_valor     <= VALOR_INICIAL;
            r_rem       <= '0;
            r_novo_jogo <= 1'b0;
            r_venc_a    <= 1'b0;
            r_venc_b    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_valor     <= w_valor_nxt;
            r_rem       <= w_rem_nxt;
            r_novo_jogo <= w_novo_jogo_nxt;
            r_venc_a    <= w_venc_a_nxt;
            r_venc_b    <= w_venc_b_nxt;
        end
    end

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_valor_nxt     = r_valor;
        w_rem_nxt       = r_rem;
        w_novo_jogo_nxt = r_novo_jogo;
        w_venc_a_nxt    = r_venc_a;
        w_venc_b_nxt    = r_venc_b;
        w_load_pa       = 1'b0;
        w_load_pb       = 1'b0;
        w_load_ta       = 1'b0;
        w_load_tb       = 1'b0;
        w_clear_t       = 1'b0;

        case (r_state)
            CLEAR_ALL: begin
                w_valor_nxt     = VALOR_INICIAL;
                w_rem_nxt       = '0;
                w_novo_jogo_nxt = 1'b0;
                w_state_nxt     = r_novo_jogo ? WAIT_RODADA : IDLE;
            end
            IDLE: ;
            WAIT_RODADA: begin
                // A round result in the same cycle takes precedence over a raise.
                if (bus.rodada_a && !bus.rodada_b) begin
                    w_state_nxt = INC_A;
                end else if (bus.rodada_b && !bus.rodada_a) begin
                    w_state_nxt = INC_B;
                end else if (bus.truco && !bus.rodada_a && !bus.rodada_b
                             && (r_valor != VALOR_MAX)) begin
                    w_valor_nxt = W_VALOR'(proximo_valor(4'(r_valor)));
                end
            end
            INC_A: begin
                w_load_ta   = 1'b1;
                w_state_nxt = CHECK_T;
            end
            INC_B: begin
                w_load_tb   = 1'b1;
                w_state_nxt = CHECK_T;
            end
            CHECK_T: begin
                if (bus.ta_igual3) begin
                    w_state_nxt = ADD_A;
                    w_rem_nxt   = r_valor;
                end else if (bus.tb_igual3) begin
                    w_state_nxt = ADD_B;
                    w_rem_nxt   = r_valor;
                end else begin
                    w_state_nxt = WAIT_RODADA;
                end
            end
            ADD_A: begin
                w_load_pa = (r_rem != '0) && !bus.a_igual12;
                if (w_load_pa) w_rem_nxt = r_rem - W_VALOR'(1);
                if ((r_rem == '0) || bus.a_igual12) w_state_nxt = NOVA_MAO;
            end
            ADD_B: begin
                w_load_pb = (r_rem != '0) && !bus.b_igual12;
                if (w_load_pb) w_rem_nxt = r_rem - W_VALOR'(1);
                if ((r_rem == '0) || bus.b_igual12) w_state_nxt = NOVA_MAO;
            end
            NOVA_MAO: begin
                w_clear_t   = 1'b1;
                w_valor_nxt = VALOR_INICIAL;
                if (bus.a_igual12 || bus.b_igual12) begin
                    w_state_nxt  = FIM;
                    w_venc_a_nxt = bus.a_igual12;
                    w_venc_b_nxt = bus.b_igual12;
                end else begin
                    w_state_nxt = WAIT_RODADA;
                end
            end
            FIM: ;
            default: w_state_nxt = CLEAR_ALL;
        endcase

        // start aborts anything in flight; CLEAR_ALL wipes partial points.
        if (bus.start) begin
            w_state_nxt     = CLEAR_ALL;
            w_novo_jogo_nxt = 1'b1;
            w_venc_a_nxt    = 1'b0;
            w_venc_b_nxt    = 1'b0;
        end
    end

    assign bus.load_pa    = w_load_pa && !reset;
    assign bus.load_pb    = w_load_pb && !reset;
    assign bus.load_ta    = w_load_ta && !reset;
    assign bus.load_tb    = w_load_tb && !reset;
    assign bus.clear_pa   = reset || (r_state == CLEAR_ALL);
    assign bus.clear_pb   = reset || (r_state == CLEAR_ALL);
    assign bus.clear_ta   = reset || (r_state == CLEAR_ALL) || w_clear_t;
    assign bus.clear_tb   = reset || (r_state == CLEAR_ALL) || w_clear_t;
    assign bus.valor_mao  = r_valor;
    assign bus.ocupado    = !(r_state inside {IDLE, WAIT_RODADA, FIM});
    assign bus.fim_jogo   = (r_state == FIM);
    assign bus.vencedor_a = r_venc_a;
    assign bus.vencedor_b = r_venc_b;

endmodule
